key_debouncer: RTL and testbench

Front-end conditioning stage for the board push-buttons (KEY0..KEYn, active-low, asynchronous, bouncy).
- Synchronises each key into clk and debounces it with a per-key stability counter.
- Emits a clean active-high level plus one-cycle press/release strobes.
- Sits directly upstream of the counter/display logic, so consumers need no local synchronisers or edge detectors.

---
 rtl/key_debouncer_if.sv | 32 +++
 rtl/key_debouncer.sv | 170 +++++++++++++++++
 tb/tb_key_debouncer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/key_debouncer_if.sv
// -----------------------------------------------------------------------------
// key_debouncer_if
//   Groups the key bus of the push-button front end.
//   key_n          raw keys, active-low, asynchronous to clk
//   pressed        debounced level per key, 1 = held
//   press_pulse    one-cycle strobe on accepted press (and auto-repeat)
//   release_pulse  one-cycle strobe on accepted release
//   master : board/stimulus side (drives key_n, observes the results)
//   slave  : debouncer side (samples key_n, drives the results)
// -----------------------------------------------------------------------------
interface key_debouncer_if #(
    parameter int N_KEYS = 3
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] pressed;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;

    modport master (
        output key_n,
        input  pressed,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  key_n,
        output pressed,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//   Synchronises and debounces N_KEYS active-low push-buttons, producing a
//   clean active-high level and one-cycle press/release strobes per key.
//   Each key is handled by an independent key_debouncer_ch instance.
//
//   Ports (top):
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     kif   key_debouncer_if.slave : key_n in, pressed/press_pulse/
//           release_pulse out (all outputs registered)
//
//   Optional feature: define KEY_AUTOREPEAT_EN to add auto-repeat press
//   strobes (first after REPEAT_DELAY cycles held, then every REPEAT_PERIOD).
//   Without the macro no repeat logic exists and REPEAT_* are unused.
// -----------------------------------------------------------------------------

// Per-key channel: 2-flop synchroniser, stability counter, output registers.
module key_debouncer_ch #(
    parameter int STABLE_CYCLES = 500000
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic pressed_o,
    output logic press_pulse_o,
    output logic release_pulse_o
);
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          mismatch, accept, rpt_fire;

    // s2 is active-low; a mismatch means the synchronised key disagrees
    // with the accepted level. The window only completes when the
    // disagreement has persisted for STABLE_CYCLES consecutive edges.
    always_comb begin
        mismatch  = (~s2_q) != pressed_q;
        accept    = mismatch && (cnt_q == CNT_LAST);
        cnt_d     = '0;
        pressed_d = pressed_q;
        release_d = 1'b0;
        if (mismatch && !accept) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (accept) begin
            pressed_d = ~s2_q;
            release_d = s2_q;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] RC_DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RC_PER_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic {
        RPT_WAIT_DELAY  = 1'b0,
        RPT_WAIT_PERIOD = 1'b1
    } rpt_state_e;

    rpt_state_e    rpt_q, rpt_d;
    logic [RW-1:0] rc_q, rc_d;

    // Repeat timing runs only while the key is held and not on an accept
    // edge; that both restarts it on press and kills it on release.
    always_comb begin
        rc_d     = '0;
        rpt_d    = RPT_WAIT_DELAY;
        rpt_fire = 1'b0;
        if (pressed_q && !accept) begin
            rpt_d = rpt_q;
            if ((rpt_q == RPT_WAIT_DELAY  && rc_q == RC_DLY_LAST) ||
                (rpt_q == RPT_WAIT_PERIOD && rc_q == RC_PER_LAST)) begin
                rpt_fire = 1'b1;
                rpt_d    = RPT_WAIT_PERIOD;
            end else begin
                rc_d = rc_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rc_q  <= '0;
            rpt_q <= RPT_WAIT_DELAY;
        end else begin
            rc_q  <= rc_d;
            rpt_q <= rpt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign press_d = (accept & ~s2_q) | rpt_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= key_n_i;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign pressed_o       = pressed_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
endmodule

module key_debouncer #(
    parameter int N_KEYS        = 3,
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic           clk,
    input  logic           rst,
    key_debouncer_if.slave kif
);
    // Reject configurations the counters cannot honour.
    if (STABLE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("key_debouncer: illegal timing parameters");
    end

    logic [N_KEYS-1:0] pressed_w, press_w, release_w;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debouncer_ch #(
            .STABLE_CYCLES (STABLE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk             (clk),
            .rst             (rst),
            .key_n_i         (kif.key_n[i]),
            .pressed_o       (pressed_w[i]),
            .press_pulse_o   (press_w[i]),
            .release_pulse_o (release_w[i])
        );
    end

    assign kif.pressed       = pressed_w;
    assign kif.press_pulse   = press_w;
    assign kif.release_pulse = release_w;
endmodule

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_debouncer
//   Directed table of {inputs, hold cycles, expected outputs}, hand-written
//   auto-repeat sequence, and randomized key activity; every edge is also
//   compared against a behavioural model of the debounce rules.
// -----------------------------------------------------------------------------
module tb_key_debouncer;
    localparam int N  = 3;
    localparam int SC = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_debouncer_if #(.N_KEYS(N)) kif ();

    key_debouncer #(
        .N_KEYS        (N),
        .STABLE_CYCLES (SC),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- behavioural model ----------------
    // The raw level is seen by the debounce rule two edges after it is
    // sampled; a key is accepted once that delayed level has disagreed with
    // the accepted level for SC consecutive edges.
    logic [N-1:0] seen [$];       // key_n samples, newest at back
    bit   [N-1:0] m_pressed, m_pp, m_rp;
    int           streak [N];
    int           held   [N];     // edges since press acceptance

    task automatic model_reset();
        seen.delete();
        seen.push_back('1);
        seen.push_back('1);
        m_pressed = '0; m_pp = '0; m_rp = '0;
        for (int i = 0; i < N; i++) begin streak[i] = 0; held[i] = 0; end
    endtask

    task automatic model_step(input logic r, input logic [N-1:0] kin);
        logic [N-1:0] old;
        if (r) begin
            model_reset();
            return;
        end
        old  = seen[0];
        m_pp = '0; m_rp = '0;
        for (int i = 0; i < N; i++) begin
            bit lvl;
            lvl = !old[i];
            streak[i] = (lvl != m_pressed[i]) ? streak[i] + 1 : 0;
            if (streak[i] == SC) begin
                streak[i]    = 0;
                m_pressed[i] = lvl;
                held[i]      = 0;
                if (lvl) m_pp[i] = 1'b1; else m_rp[i] = 1'b1;
            end else if (m_pressed[i]) begin
                held[i]++;
                if (AR && held[i] >= RD && ((held[i] - RD) % RP) == 0) m_pp[i] = 1'b1;
            end
        end
        void'(seen.pop_front());
        seen.push_back(kin);
    endtask

    // ---------------- checking ----------------
    task automatic cmp(input string name, input logic [N-1:0] ep, input logic [N-1:0] epp,
                       input logic [N-1:0] erp);
        vectors++;
        if (kif.pressed !== ep || kif.press_pulse !== epp || kif.release_pulse !== erp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got pressed=%b pp=%b rp=%b, want pressed=%b pp=%b rp=%b",
                     name, $time, kif.pressed, kif.press_pulse, kif.release_pulse, ep, epp, erp);
        end
    endtask

    // One clock edge with current inputs, then compare against the model.
    task automatic tick();
        logic [N-1:0] kin;
        logic         r;
        kin = kif.key_n;
        r   = rst;
        @(posedge clk);
        model_step(r, kin);
        #1;
        cmp("model", m_pressed, m_pp, m_rp);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string        name;
        logic         rst;
        logic [N-1:0] key_n;
        int           cycles;
        logic [N-1:0] pressed;
        logic [N-1:0] pp;
        logic [N-1:0] rp;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(input string nm, input logic r, input logic [N-1:0] k,
                                input int c, input logic [N-1:0] p, input logic [N-1:0] pp,
                                input logic [N-1:0] rp);
        vec_t v;
        v.name = nm; v.rst = r; v.key_n = k; v.cycles = c;
        v.pressed = p; v.pp = pp; v.rp = rp;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [N-1:0] ep;
        int           phase_p;

        kif.key_n = '1;
        rst       = 1'b1;
        model_reset();
        @(negedge clk);

        //   name            rst key_n   cyc pressed pp      rp
        add("reset",         1, 3'b111,  3, 3'b000, 3'b000, 3'b000);
        add("idle",          0, 3'b111, 20, 3'b000, 3'b000, 3'b000);
        add("press1_pre",    0, 3'b101,  5, 3'b000, 3'b000, 3'b000);
        add("press1_edge6",  0, 3'b101,  1, 3'b010, 3'b010, 3'b000);
        add("press1_after",  0, 3'b101,  1, 3'b010, 3'b000, 3'b000);
        add("rel1_edge6",    0, 3'b111,  6, 3'b000, 3'b000, 3'b010);
        add("rel1_after",    0, 3'b111,  1, 3'b000, 3'b000, 3'b000);
        add("bounce_lo1",    0, 3'b110,  3, 3'b000, 3'b000, 3'b000);
        add("bounce_hi",     0, 3'b111,  1, 3'b000, 3'b000, 3'b000);
        add("bounce_lo2",    0, 3'b110,  3, 3'b000, 3'b000, 3'b000);
        add("bounce_end",    0, 3'b111,  3, 3'b000, 3'b000, 3'b000);
        add("hold0_pre",     0, 3'b110,  5, 3'b000, 3'b000, 3'b000);
        add("hold0_edge6",   0, 3'b110,  1, 3'b001, 3'b001, 3'b000);
        add("press2_edge6",  0, 3'b010,  6, 3'b101, 3'b100, 3'b000);
        add("both_held",     0, 3'b010,  2, 3'b101, 3'b000, 3'b000);
        // key0 was accepted 13 edges before the end of this step, so with
        // auto-repeat its second repeat (P+13) lands on that edge.
        add("rel02_pre",     0, 3'b111,  5, 3'b101, AR ? 3'b001 : 3'b000, 3'b000);
        add("rel02_edge6",   0, 3'b111,  1, 3'b000, 3'b000, 3'b101);
        add("rel02_after",   0, 3'b111,  1, 3'b000, 3'b000, 3'b000);
        add("mid_pre_rst",   0, 3'b011,  2, 3'b000, 3'b000, 3'b000);
        add("mid_rst",       1, 3'b011,  1, 3'b000, 3'b000, 3'b000);
        add("post_rst_pre",  0, 3'b011,  5, 3'b000, 3'b000, 3'b000);
        add("post_rst_edge", 0, 3'b011,  1, 3'b100, 3'b100, 3'b000);
        add("final_release", 0, 3'b111,  7, 3'b000, 3'b000, 3'b000);

        foreach (tbl[t]) begin
            rst       = tbl[t].rst;
            kif.key_n = tbl[t].key_n;
            for (int c = 0; c < tbl[t].cycles; c++) tick();
            cmp(tbl[t].name, tbl[t].pressed, tbl[t].pp, tbl[t].rp);
            @(negedge clk);
        end

        // ---------------- auto-repeat sequence ----------------
        rst = 1'b1; tick(); @(negedge clk); rst = 1'b0;
        kif.key_n = 3'b110;
        for (int c = 0; c < 5; c++) tick();
        tick();                                   // edge P
        cmp("rpt_accept", 3'b001, 3'b001, 3'b000);
        for (int k = 1; k <= 17; k++) begin
            tick();
            ep = (AR && (k == RD || k == RD + RP || k == RD + 2 * RP)) ? 3'b001 : 3'b000;
            cmp("rpt_hold", 3'b001, ep, 3'b000);
        end
        @(negedge clk);
        kif.key_n = 3'b111;
        // Release begins at P+18; repeats continue until acceptance at P+23.
        for (int k = 1; k <= 6; k++) begin
            tick();
            ep = (AR && (k == 2 || k == 5)) ? 3'b001 : 3'b000;
            cmp("rpt_release", (k == 6) ? 3'b000 : 3'b001, ep, (k == 6) ? 3'b001 : 3'b000);
        end
        for (int k = 0; k < 15; k++) begin
            tick();
            cmp("rpt_quiet", 3'b000, 3'b000, 3'b000);
        end

        // ---------------- randomized activity ----------------
        @(negedge clk);
        phase_p = 8;
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] k;
            if (c % 100 == 0) begin
                case ($urandom_range(2))
                    0:       phase_p = 2;
                    1:       phase_p = 8;
                    default: phase_p = 40;
                endcase
            end
            k = kif.key_n;
            for (int i = 0; i < N; i++)
                if ($urandom_range(phase_p - 1) == 0) k[i] = ~k[i];
            kif.key_n = k;
            rst = ($urandom_range(299) == 0);
            tick();
            @(negedge clk);
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
